// File: rtl/nibble_mem_arbiter.sv
// rtl/nibble_mem_arbiter.sv - CPU/program-loader arbiter onto one single-port synchronous memory
// CPU has priority unless the loader has waited MAXWAIT cycles; read data returns one cycle after grant.
module nibble_mem_arbiter #(
    parameter int WIDTH    = 4,
    parameter int ADDRSIZE = 8,
    parameter int MAXWAIT  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDRSIZE-1:0] cpu_addr,
    input  logic [WIDTH-1:0]    cpu_wdata,
    output logic                cpu_gnt,
    output logic                cpu_rvalid,
    output logic [WIDTH-1:0]    cpu_rdata,
    input  logic                ldr_req,
    input  logic                ldr_we,
    input  logic [ADDRSIZE-1:0] ldr_addr,
    input  logic [WIDTH-1:0]    ldr_wdata,
    output logic                ldr_gnt,
    output logic                ldr_rvalid,
    output logic [WIDTH-1:0]    ldr_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDRSIZE-1:0] mem_addr,
    output logic [WIDTH-1:0]    mem_wdata,
    input  logic [WIDTH-1:0]    mem_rdata,
    output logic [3:0]          wait_cnt
);

    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_LDR} owner_t;

    owner_t     owner_q, owner_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       ldr_starved;

    always_comb begin
        ldr_starved = (wait_cnt_q >= 4'(MAXWAIT)) && ldr_req;
        cpu_gnt     = reset && cpu_req && !ldr_starved;
        ldr_gnt     = reset && ldr_req && (ldr_starved || !cpu_req);
        mem_en      = cpu_gnt || ldr_gnt;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (ldr_gnt) begin
            mem_we    = ldr_we;
            mem_addr  = ldr_addr;
            mem_wdata = ldr_wdata;
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (cpu_gnt && !cpu_we) begin
            owner_d = OWN_CPU;
        end else if (ldr_gnt && !ldr_we) begin
            owner_d = OWN_LDR;
        end
        wait_cnt_d = wait_cnt_q;
        if (ldr_gnt) begin
            wait_cnt_d = 4'd0;
        end else if (ldr_req && wait_cnt_q != 4'hF) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            owner_q    <= OWN_NONE;
            wait_cnt_q <= 4'd0;
        end else begin
            owner_q    <= owner_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Returns are also masked while reset is held so a read in flight at reset never surfaces.
    always_comb begin
        cpu_rvalid = reset && (owner_q == OWN_CPU);
        ldr_rvalid = reset && (owner_q == OWN_LDR);
        cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
        ldr_rdata  = ldr_rvalid ? mem_rdata : '0;
        wait_cnt   = wait_cnt_q;
    end

endmodule
